// File: rtl/perf_pkg.sv
// perf_pkg: shared constants for the performance CSR block
//   ADDR_*  : register addresses seen on the access port
//   state_t : counting state (RUN counts, FROZEN holds after a halt)
package perf_pkg;

    localparam logic [1:0] ADDR_CYC_LO = 2'd0;
    localparam logic [1:0] ADDR_CYC_HI = 2'd1;
    localparam logic [1:0] ADDR_INS_LO = 2'd2;
    localparam logic [1:0] ADDR_INS_HI = 2'd3;

    typedef enum logic {
        RUN    = 1'b0,
        FROZEN = 1'b1
    } state_t;

endpackage

// File: rtl/perf_cnt.sv
// perf_cnt: wrapping accumulator with clear, enable and increment
//   clk, rst : clock, synchronous active-high reset
//   clr      : zero the count this cycle (wins over en)
//   en       : add inc this cycle
//   inc      : amount added when enabled
//   nxt      : value the count takes at the coming edge
module perf_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] inc,
    output logic [W-1:0] nxt
);

    logic [W-1:0] cnt;

    // the next value is exported so reads see this cycle's update
    assign nxt = clr ? '0 : en ? cnt + inc : cnt;

    always_ff @(posedge clk) begin
        cnt <= rst ? '0 : nxt;
    end

endmodule

// File: rtl/perf_csr.sv
// perf_csr: cycle and retired-instruction counters behind a small CSR port
//   clk, rst    : clock, synchronous active-high reset
//   isHalt      : core halted; counting stops after the current cycle
//   W_v         : instructions retired this cycle
//   req/we/addr : one-cycle access request; a write clears a counter
//   ack/rdata   : response one cycle after the request; rdata 0 unless reading
//   frozen      : counting has stopped because of a halt
module perf_csr
    import perf_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              isHalt,
    input  logic [2:0]        W_v,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        addr,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              frozen
);

    state_t            state;
    logic              run;
    logic              rd;
    logic              wr;
    logic              ack_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] snap_cyc;
    logic [DATA_W-1:0] snap_ins;
    logic [CNT_W-1:0]  cyc_nxt;
    logic [CNT_W-1:0]  ins_nxt;

    assign run = state == RUN;
    assign rd  = req && !we;
    assign wr  = req && we;

    perf_cnt #(.W(CNT_W)) u_cyc (
        .clk (clk),
        .rst (rst),
        .clr (wr && !addr[1]),
        .en  (run),
        .inc ({{(CNT_W-1){1'b0}}, 1'b1}),
        .nxt (cyc_nxt)
    );

    perf_cnt #(.W(CNT_W)) u_ins (
        .clk (clk),
        .rst (rst),
        .clr (wr && addr[1]),
        .en  (run),
        .inc ({{(CNT_W-3){1'b0}}, W_v}),
        .nxt (ins_nxt)
    );

    // low halves come from the freshly updated count, high halves from the
    // snapshot taken by the matching low-half read
    always_comb begin
        rd_val = addr == ADDR_CYC_LO ? cyc_nxt[DATA_W-1:0] :
                 addr == ADDR_CYC_HI ? snap_cyc :
                 addr == ADDR_INS_LO ? ins_nxt[DATA_W-1:0] : snap_ins;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            snap_cyc <= '0;
            snap_ins <= '0;
        end else begin
            if (run && isHalt)
                state <= FROZEN;
            ack_q   <= req;
            rdata_q <= rd ? rd_val : '0;
            if (rd && addr == ADDR_CYC_LO)
                snap_cyc <= cyc_nxt[CNT_W-1:DATA_W];
            if (rd && addr == ADDR_INS_LO)
                snap_ins <= ins_nxt[CNT_W-1:DATA_W];
        end
    end

    // a response pending when reset arrives is suppressed immediately
    assign ack    = ack_q && !rst;
    assign rdata  = ack ? rdata_q : '0;
    assign frozen = state == FROZEN;

endmodule
